if_fetch_unit: RTL and testbench

Instruction-fetch stage of the pipelined MIPS core, directly upstream of the IF/ID pipeline register. It owns the PC and issues one word-aligned fetch at a time to a variable-latency instruction memory over a req/ready + rvalid handshake. It presents {pcplus4, instr, if_valid} to IF/ID, holds the instruction while the hazard unit stalls, and redirects on branch/jump resolution. Glue outside the block drives IF/ID flush as redirect | ~if_valid.

---
 rtl/if_fetch_unit_if.sv | 26 ++
 rtl/if_fetch_unit.sv | 168 ++++++++++++++++
 tb/tb_if_fetch_unit.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory fetch bus: single outstanding req/ready request, rvalid/rdata response.
interface if_fetch_unit_if #(
  parameter int WIDTH = 32
);
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_ready;
  logic             imem_rvalid;
  logic [WIDTH-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// MIPS instruction-fetch stage: owns the PC, fetches one word at a time, holds under stall, redirects.
// Optional IF_PERF_CNT_EN adds fetch_count/bubble_count performance counters.
module if_fetch_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  if_fetch_unit_if.master  imem_bus,
  output logic [WIDTH-1:0] pcplus4,
  output logic [WIDTH-1:0] instr,
  output logic             if_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]      fetch_count,
  output logic [31:0]      bubble_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pcplus4_q, pcplus4_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] addr_q;
  logic             discard_q, discard_d;
  logic             req_q;
  logic             if_valid_q;
  logic [WIDTH-1:0] target_s;
  logic [WIDTH-1:0] pc_inc_s;
  logic             consume_s;

  // Masking keeps every redirect_pc bit in use while forcing word alignment.
  assign target_s  = redirect_pc & {{(WIDTH-2){1'b1}}, 2'b00};
  assign pc_inc_s  = pc_q + WIDTH'(3'd4);
  assign consume_s = (state_q == S_HOLD) && !stall && !redirect;

  // Next-state, PC and presented-instruction logic; redirect outranks stall.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    discard_d = discard_q;
    pcplus4_d = pcplus4_q;
    instr_d   = instr_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (redirect) pc_d = target_s;
        else          pc_d = pc_q;
      end
      S_REQ: begin
        if (imem_bus.imem_ready) state_d = S_WAIT;
        else                     state_d = S_REQ;
        if (redirect) begin
          pc_d      = target_s;
          discard_d = imem_bus.imem_ready;
        end else begin
          discard_d = 1'b0;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          pc_d = target_s;
          if (imem_bus.imem_rvalid) begin
            discard_d = 1'b0;
            state_d   = S_REQ;
          end else begin
            discard_d = 1'b1;
            state_d   = S_WAIT;
          end
        end else if (imem_bus.imem_rvalid) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = S_REQ;
          end else begin
            state_d   = S_HOLD;
            instr_d   = imem_bus.imem_rdata;
            pcplus4_d = pc_inc_s;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_HOLD: begin
        if (redirect || !stall) begin
          // Leaving HOLD: the presented word goes back to a NOP.
          if (redirect) pc_d = target_s;
          else          pc_d = pc_inc_s;
          state_d   = S_REQ;
          instr_d   = '0;
          pcplus4_d = '0;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d   = S_IDLE;
        discard_d = 1'b0;
        instr_d   = '0;
        pcplus4_d = '0;
      end
    endcase
  end

  // State, PC and registered bus/IF-ID outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      discard_q  <= 1'b0;
      pcplus4_q  <= '0;
      instr_q    <= '0;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
      if_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      discard_q  <= discard_d;
      pcplus4_q  <= pcplus4_d;
      instr_q    <= instr_d;
      addr_q     <= pc_d;
      req_q      <= (state_d == S_REQ);
      if_valid_q <= (state_d == S_HOLD);
    end
  end

  assign imem_bus.imem_req  = req_q;
  assign imem_bus.imem_addr = addr_q;
  assign pcplus4            = pcplus4_q;
  assign instr              = instr_q;
  assign if_valid           = if_valid_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] bubble_count_q, bubble_count_d;

  assign fetch_count_d  = consume_s ? (fetch_count_q + 32'd1) : fetch_count_q;
  assign bubble_count_d = (!if_valid_q || stall) ? (bubble_count_q + 32'd1) : bubble_count_q;

  // Consumed-instruction and bubble-cycle counters, wrapping modulo 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count_q  <= 32'd0;
      bubble_count_q <= 32'd0;
    end else begin
      fetch_count_q  <= fetch_count_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign fetch_count  = fetch_count_q;
  assign bubble_count = bubble_count_q;
`else
  logic unused_consume_s;
  assign unused_consume_s = consume_s;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit: latency, stall, redirects, PC wrap, reset mid-fetch.
module tb_if_fetch_unit;
  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pcplus4;
  logic [31:0] instr;
  logic        if_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] bubble_count;
`endif
  int checks = 0;
  int errors = 0;

  if_fetch_unit_if #(.WIDTH(32)) bus ();

  if_fetch_unit #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_bus    (bus.master),
    .pcplus4     (pcplus4),
    .instr       (instr),
    .if_valid    (if_valid)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_count (fetch_count),
    .bubble_count(bubble_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts in REQ with ready high; accepts, returns w one cycle later, ends in HOLD.
  task automatic fetch(input logic [31:0] w, input logic [31:0] exp_pc4, input string tag);
    chk({tag, "_req"}, {31'd0, bus.imem_req}, 32'd1);
    step();
    chk({tag, "_wait_req"}, {31'd0, bus.imem_req}, 32'd0);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = w;
    step();
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'd0;
    chk({tag, "_valid"}, {31'd0, if_valid}, 32'd1);
    chk({tag, "_instr"}, instr, w);
    chk({tag, "_pc4"}, pcplus4, exp_pc4);
  endtask

  task automatic chk_req(input string tag, input logic [31:0] addr);
    chk({tag, "_req"}, {31'd0, bus.imem_req}, 32'd1);
    chk({tag, "_addr"}, bus.imem_addr, addr);
    chk({tag, "_nvalid"}, {31'd0, if_valid}, 32'd0);
    chk({tag, "_nop"}, instr, 32'd0);
  endtask

  initial begin
    rst_n           = 1'b0;
    stall           = 1'b0;
    redirect        = 1'b0;
    redirect_pc     = 32'd0;
    bus.imem_ready  = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'd0;
    step();
    step();
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_addr", bus.imem_addr, 32'd0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc4", pcplus4, 32'd0);
    rst_n          = 1'b1;
    bus.imem_ready = 1'b1;

    step();
    chk_req("first", 32'h0000_0000);
    fetch(32'h2408_0001, 32'h0000_0004, "f0");
    step();
    chk_req("next4", 32'h0000_0004);
    fetch(32'h2409_0002, 32'h0000_0008, "f1");
    step();
    chk_req("next8", 32'h0000_0008);
    fetch(32'h010A_5820, 32'h0000_000C, "f2");

    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_valid", {31'd0, if_valid}, 32'd1);
      chk("stall_instr", instr, 32'h010A_5820);
      chk("stall_pc4", pcplus4, 32'h0000_000C);
      chk("stall_noreq", {31'd0, bus.imem_req}, 32'd0);
    end
    stall = 1'b0;
    step();
    chk_req("after_stall", 32'h0000_000C);
    fetch(32'hAC0B_0010, 32'h0000_0010, "f3");
    step();
    chk_req("next10", 32'h0000_0010);

    step();
    chk("wait10_req", {31'd0, bus.imem_req}, 32'd0);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    step();
    redirect = 1'b0;
    chk("redir_wait_valid", {31'd0, if_valid}, 32'd0);
    chk("redir_wait_req", {31'd0, bus.imem_req}, 32'd0);
    step();
    chk("redir_wait2_valid", {31'd0, if_valid}, 32'd0);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    step();
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'd0;
    chk_req("drop", 32'h0000_0100);
    fetch(32'h1000_0003, 32'h0000_0104, "f4");

    stall       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0203;
    step();
    stall    = 1'b0;
    redirect = 1'b0;
    chk_req("hold_redir", 32'h0000_0200);
    chk("hold_redir_pc4", pcplus4, 32'd0);

    bus.imem_ready = 1'b0;
    redirect       = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    step();
    redirect = 1'b0;
    chk_req("req_redir", 32'hFFFF_FFFC);
    step();
    chk_req("req_unready", 32'hFFFF_FFFC);
    bus.imem_ready = 1'b1;
    fetch(32'h0800_0000, 32'h0000_0000, "wrap");
    step();
    chk_req("wrap_next", 32'h0000_0000);

    fetch(32'h2408_0001, 32'h0000_0004, "f6");
    step();
    chk_req("pre_rst", 32'h0000_0004);
    step();
    chk("pre_rst_wait", {31'd0, bus.imem_req}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("mid_rst_addr", bus.imem_addr, 32'd0);
    chk("mid_rst_valid", {31'd0, if_valid}, 32'd0);
    chk("mid_rst_instr", instr, 32'd0);
    chk("mid_rst_pc4", pcplus4, 32'd0);
`ifdef IF_PERF_CNT_EN
    chk("mid_rst_fetch_cnt", fetch_count, 32'd0);
    chk("mid_rst_bubble_cnt", bubble_count, 32'd0);
`endif
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hBAAD_F00D;
    step();
    rst_n = 1'b1;
    step();
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'd0;
    chk_req("restart", 32'h0000_0000);
    fetch(32'h2402_000A, 32'h0000_0004, "f7");
    step();
    chk_req("restart_next", 32'h0000_0004);
`ifdef IF_PERF_CNT_EN
    chk("fetch_cnt_one", fetch_count, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
